alu_op_decoder: RTL and testbench
=================================

ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction and immediate width.
REQ-002 The block SHALL have parameter OPCODE_LENGTH, default 4, giving the ALU operation code width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  DATA_WIDTH  RV32I instruction word.
REQ-006 in_valid / in_ready  input / output  1 each  upstream handshake; transfer when both are high at a clock edge.
REQ-007 flush  input  1  discards all buffered entries.
REQ-008 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-009 alu_op  output  OPCODE_LENGTH  ALU operation code.
REQ-010 imm  output  DATA_WIDTH  sign-extended immediate.
REQ-011 rs1, rs2, rd  output  5 each  register indices.
REQ-012 alu_src_imm, reg_write, is_branch, illegal  output  1 each  operand-B-is-immediate, writeback enable, branch compare, unsupported encoding.

Function
REQ-013 ALU op encoding SHALL be AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, SLL 0111, EQ 1000, NE 1001, GE 1010, LT 1100, SRA 1110, SRL 1111.
REQ-014 The R-type mapping (opcode 0110011) SHALL be funct3 000 to ADD, or to SUB when funct7=0100000; 111 AND; 110 OR; 100 XOR; 001 SLL; 010 LT; 101 SRL, or SRA when funct7=0100000; with reg_write=1 and alu_src_imm=0.
REQ-015 The I-type ALU mapping (opcode 0010011) SHALL be the same as R-type except that 000 always maps to ADD; it SHALL use imm = sext(instr[31:20]), alu_src_imm=1 and reg_write=1.
REQ-016 The load (0000011) and store (0100011) mapping SHALL be ADD with alu_src_imm=1, using I-immediate for loads and S-immediate sext({instr[31:25],instr[11:7]}) for stores; reg_write SHALL be 1 for loads and 0 for stores.
REQ-017 The branch mapping (1100011) SHALL be funct3 000 EQ, 001 NE, 100 LT, 101 GE, with is_branch=1, reg_write=0 and B-immediate sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
REQ-018 Every other opcode/funct combination SHALL decode to alu_op=0000, reg_write=0 and is_branch=0, with the illegal output governed by REQ-029/REQ-030.
REQ-019 Decode SHALL occur on the input side; each buffer entry SHALL hold decoded fields only.
REQ-020 Buffering SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-021 Buffer state transitions SHALL be: accept with no pop increments the count, pop with no accept decrements it, and simultaneous accept and pop holds the count.
REQ-022 in_ready SHALL be registered and SHALL equal 1 exactly when state is not TWO.
REQ-023 Latency SHALL be 1 cycle: an instruction accepted in EMPTY SHALL appear with out_valid=1 on the next cycle.
REQ-024 Order SHALL be strictly FIFO; when a pop occurs in TWO, the second entry SHALL become head on the next cycle.
REQ-025 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL take precedence over accept and pop: on the next cycle the state SHALL be EMPTY and out_valid=0, and any instruction presented in the flush cycle SHALL be dropped.

Reset
REQ-027 While reset is high, the block SHALL hold state EMPTY, out_valid=0 and in_ready=0, with all payload outputs at 0.
REQ-028 On the first cycle after reset deasserts, in_ready SHALL be 1; reset asserted mid-operation SHALL discard all entries.

Configuration
REQ-029 When ALU_DEC_ILLEGAL_EN is defined, illegal SHALL be 1 for REQ-018 encodings, including BLTU/BGEU and unsupported funct7 values.
REQ-030 When ALU_DEC_ILLEGAL_EN is undefined, illegal SHALL be tied to 0 and SHALL occupy no buffer storage.

Structure
REQ-031 Package alu_dec_pkg SHALL hold the RV32I opcode constants, the ALU op code typedef enum per REQ-013, and the decoded-entry struct typedef.
REQ-032 Combinational decode SHALL be in sub-module alu_dec_comb, instantiated once on the input side.

Verification
REQ-033 Input 0x002081B3 (add x3,x1,x2) SHALL produce, next cycle, out_valid=1, alu_op=0010, rs1=1, rs2=2, rd=3, reg_write=1, alu_src_imm=0.
REQ-034 Input 0x40335293 (srai x5,x6,3) SHALL produce alu_op=1110, imm=0x00000403, rd=5, alu_src_imm=1.
REQ-035 Input 0xFE209CE3 (bne x1,x2,-8) SHALL produce alu_op=1001, imm=0xFFFFFFF8, is_branch=1, reg_write=0.
REQ-036 With out_ready=0 and three back-to-back instructions, two SHALL be accepted, in_ready SHALL drop after the second, and raising out_ready SHALL deliver all three in order.
REQ-037 flush in state TWO with in_valid=1 SHALL give out_valid=0 and in_ready=1 next cycle, with the presented instruction never emitted.
REQ-038 Input 0xFFFFFFFF SHALL give illegal=1 with the macro defined and illegal=0 without it; in both builds alu_op=0000 and reg_write=0.

Source files
------------

// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg: shared definitions for the RV32I ALU operation decoder.
//   - RV32I major opcode and funct7 constants
//   - alu_op_e: ALU operation codes
//   - dec_entry_t: one decoded instruction as held in the output buffer
// Configuration macro: ALU_DEC_ILLEGAL_EN adds an 'illegal' bit to each
// decoded entry; without it the entry carries no illegal storage.
package alu_dec_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_NE  = 4'b1001,
    ALU_GE  = 4'b1010,
    ALU_LT  = 4'b1100,
    ALU_SRA = 4'b1110,
    ALU_SRL = 4'b1111
  } alu_op_e;

  typedef struct packed {
    alu_op_e         alu_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            alu_src_imm;
    logic            reg_write;
    logic            is_branch;
`ifdef ALU_DEC_ILLEGAL_EN
    logic            illegal;
`endif
  } dec_entry_t;

endpackage

// File: rtl/alu_dec_comb.sv
// alu_dec_comb: purely combinational RV32I decode into a dec_entry_t.
// Ports:
//   instr  in   XLEN-bit instruction word
//   dec    out  decoded entry (ALU op, immediate, register indices, flags)
// Register index fields are always the raw instruction fields. Any
// unsupported encoding yields alu_op=0000 with imm, alu_src_imm,
// reg_write and is_branch all 0.
// Configuration macro: ALU_DEC_ILLEGAL_EN exposes the unsupported-encoding
// flag in dec.illegal.
module alu_dec_comb
  import alu_dec_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_entry_t      dec
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            f7_base;
  logic            f7_alt;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;

  alu_op_e         op;
  logic [XLEN-1:0] imm;
  logic            src_imm;
  logic            wr;
  logic            br;
  logic            bad;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                  instr[11:8], 1'b0};

  always_comb begin
    op      = ALU_AND;
    imm     = '0;
    src_imm = 1'b0;
    wr      = 1'b0;
    br      = 1'b0;
    bad     = 1'b0;
    case (opcode)
      OPC_OP: begin
        wr = 1'b1;
        case (funct3)
          3'b000: begin
            op  = f7_alt ? ALU_SUB : ALU_ADD;
            bad = !(f7_base || f7_alt);
          end
          3'b101: begin
            op  = f7_alt ? ALU_SRA : ALU_SRL;
            bad = !(f7_base || f7_alt);
          end
          3'b111: begin op = ALU_AND; bad = !f7_base; end
          3'b110: begin op = ALU_OR;  bad = !f7_base; end
          3'b100: begin op = ALU_XOR; bad = !f7_base; end
          3'b001: begin op = ALU_SLL; bad = !f7_base; end
          3'b010: begin op = ALU_LT;  bad = !f7_base; end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        wr      = 1'b1;
        src_imm = 1'b1;
        imm     = imm_i;
        // Only the shift-immediates carry funct7 in the instruction; for the
        // rest those bits are part of the immediate and are not checked.
        case (funct3)
          3'b000: op = ALU_ADD;
          3'b111: op = ALU_AND;
          3'b110: op = ALU_OR;
          3'b100: op = ALU_XOR;
          3'b010: op = ALU_LT;
          3'b001: begin op = ALU_SLL; bad = !f7_base; end
          3'b101: begin
            op  = f7_alt ? ALU_SRA : ALU_SRL;
            bad = !(f7_base || f7_alt);
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        op      = ALU_ADD;
        src_imm = 1'b1;
        wr      = 1'b1;
        imm     = imm_i;
      end
      OPC_STORE: begin
        op      = ALU_ADD;
        src_imm = 1'b1;
        imm     = imm_s;
      end
      OPC_BRANCH: begin
        br  = 1'b1;
        imm = imm_b;
        case (funct3)
          3'b000:  op = ALU_EQ;
          3'b001:  op = ALU_NE;
          3'b100:  op = ALU_LT;
          3'b101:  op = ALU_GE;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      op      = ALU_AND;
      imm     = '0;
      src_imm = 1'b0;
      wr      = 1'b0;
      br      = 1'b0;
    end
  end

  always_comb begin
    dec             = '0;
    dec.alu_op      = op;
    dec.imm         = imm;
    dec.rs1         = instr[19:15];
    dec.rs2         = instr[24:20];
    dec.rd          = instr[11:7];
    dec.alu_src_imm = src_imm;
    dec.reg_write   = wr;
    dec.is_branch   = br;
`ifdef ALU_DEC_ILLEGAL_EN
    dec.illegal     = bad;
`endif
  end

endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: RV32I ALU operation decoder with a 2-entry skid buffer.
// Instructions are decoded as they arrive; only decoded fields are buffered.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr, in_valid, in_ready  upstream instruction handshake
//   flush                      drop all buffered entries (beats accept/pop)
//   out_valid, out_ready       downstream handshake
//   alu_op, imm, rs1, rs2, rd  decoded head entry
//   alu_src_imm, reg_write, is_branch, illegal   decoded head flags
// Configuration macro: ALU_DEC_ILLEGAL_EN enables the illegal output;
// without it illegal is tied low and not stored.
//
// state | meaning
// EMPTY | no entries, out_valid=0
// ONE   | head valid, tail free
// TWO   | head and tail valid, in_ready=0
module alu_op_decoder
  import alu_dec_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]    imm,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic                     alu_src_imm,
  output logic                     reg_write,
  output logic                     is_branch,
  output logic                     illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  buf_state_e state_q;
  buf_state_e state_nxt;
  logic       in_ready_q;
  dec_entry_t dec;
  dec_entry_t head_q;
  dec_entry_t tail_q;
  logic       accept;
  logic       pop;
  logic       load_head;
  logic       load_tail;
  logic       shift_tail;

  alu_dec_comb u_dec (
    .instr (instr[XLEN-1:0]),
    .dec   (dec)
  );

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_nxt  = state_q;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_head = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_head = 1'b1;
          end else if (accept) begin
            load_tail = 1'b1;
            state_nxt = TWO;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            shift_tail = 1'b1;
            state_nxt  = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= dec;
      end else if (shift_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= dec;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign alu_op      = OPCODE_LENGTH'(head_q.alu_op);
  assign imm         = DATA_WIDTH'(head_q.imm);
  assign rs1         = head_q.rs1;
  assign rs2         = head_q.rs2;
  assign rd          = head_q.rd;
  assign alu_src_imm = head_q.alu_src_imm;
  assign reg_write   = head_q.reg_write;
  assign is_branch   = head_q.is_branch;
`ifdef ALU_DEC_ILLEGAL_EN
  assign illegal     = head_q.illegal;
`else
  assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: directed cases followed by random
// traffic, compared against a queue-based model with table-driven decode.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        alu_src_imm, reg_write, is_branch, illegal;

  always #5 clk = ~clk;

  alu_op_decoder #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .imm(imm), .rs1(rs1), .rs2(rs2),
    .rd(rd), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .is_branch(is_branch), .illegal(illegal)
  );

`ifdef ALU_DEC_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        src, wr, br, ill;
  } exp_t;

  // funct3-indexed op tables: base funct7, alternate funct7, branches.
  localparam logic [3:0] OPS_BASE [8] = '{4'h2, 4'h7, 4'hC, 4'h0, 4'h5, 4'hF, 4'h1, 4'h0};
  localparam logic [3:0] OPS_ALT  [8] = '{4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE, 4'h0, 4'h0};
  localparam logic [3:0] OPS_BR   [8] = '{4'h8, 4'h9, 4'h0, 4'h0, 4'hC, 4'hA, 4'h0, 4'h0};
  localparam logic [7:0] OK_BASE = 8'b1111_0111;
  localparam logic [7:0] OK_ALT  = 8'b0010_0001;
  localparam logic [7:0] OK_BR   = 8'b0011_0011;

  exp_t q[$];
  bit   m_rdy, m_rst, m_known;
  int   n_checks, n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   sw, f3, f7;
    bit   ok;
    sw = w;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    e = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    ok = 1'b0;
    case (w[6:0])
      7'h33: begin
        if (f7 == 0 && OK_BASE[f3]) begin ok = 1'b1; e.op = OPS_BASE[f3]; end
        else if (f7 == 32 && OK_ALT[f3]) begin ok = 1'b1; e.op = OPS_ALT[f3]; end
        e.wr = 1'b1;
      end
      7'h13: begin
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
        else ok = OK_BASE[f3];
        e.op  = (f3 == 5 && f7 == 32) ? 4'hE : OPS_BASE[f3];
        e.wr  = 1'b1;
        e.src = 1'b1;
        e.imm = sw >>> 20;
      end
      7'h03: begin
        ok = 1'b1; e.op = 4'h2; e.wr = 1'b1; e.src = 1'b1; e.imm = sw >>> 20;
      end
      7'h23: begin
        ok = 1'b1; e.op = 4'h2; e.src = 1'b1;
        e.imm = ((sw >>> 25) << 5) | int'(w[11:7]);
      end
      7'h63: begin
        ok = OK_BR[f3]; e.op = OPS_BR[f3]; e.br = 1'b1;
        e.imm = ((sw >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5)
                | (int'(w[11:8]) << 1);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.op = '0; e.imm = '0; e.src = 1'b0; e.wr = 1'b0; e.br = 1'b0;
    end
    e.ill = !ok;
    return e;
  endfunction

  task automatic check_outputs();
    exp_t h;
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    if (m_rst) begin
      check("rst_payload",
            64'({alu_op, imm, rs1, rs2, rd, alu_src_imm, reg_write, is_branch, illegal}), 64'(0));
    end else if (q.size() != 0) begin
      h = q[0];
      check("alu_op", 64'(alu_op), 64'(h.op));
      check("imm", 64'(imm), 64'(h.imm));
      check("regs", 64'({rs1, rs2, rd}), 64'({h.rs1, h.rs2, h.rd}));
      check("flags", 64'({alu_src_imm, reg_write, is_branch}), 64'({h.src, h.wr, h.br}));
      check("illegal", 64'(illegal), 64'(ILL_EN & h.ill));
    end
  endtask

  // One cycle: check outputs, drive inputs at the falling edge, advance model.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic fl, input logic ordy);
    bit acc, pp;
    @(negedge clk);
    if (m_known) check_outputs();
    reset = r; in_valid = v; instr = ins; flush = fl; out_ready = ordy;
    if (r) begin
      q.delete(); m_rdy = 1'b0; m_rst = 1'b1; m_known = 1'b1;
    end else if (fl) begin
      q.delete(); m_rdy = 1'b1; m_rst = 1'b0;
    end else begin
      acc = v && m_rdy;
      pp  = (q.size() != 0) && ordy;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(ins));
      m_rdy = (q.size() < 2);
      m_rst = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [6];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};
    w = $urandom();
    k = $urandom_range(0, 6);
    if (k < 6) w[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] I_A = 32'h00100513;  // addi x10,x0,1
  localparam logic [31:0] I_B = 32'h00200593;  // addi x11,x0,2
  localparam logic [31:0] I_C = 32'h00300613;  // addi x12,x0,3
  localparam logic [31:0] I_D = 32'h00700693;  // addi x13,x0,7

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
    n_checks = 0; n_pass = 0; m_known = 1'b0; m_rdy = 1'b0; m_rst = 1'b1;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    step(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    step(0, 1, 32'h002081B3, 0, 1);
    @(posedge clk); #1;
    check("add_valid", 64'(out_valid), 64'(1));
    check("add_op", 64'(alu_op), 64'(4'b0010));
    check("add_regs", 64'({rs1, rs2, rd}), 64'({5'd1, 5'd2, 5'd3}));
    check("add_flags", 64'({reg_write, alu_src_imm}), 64'(2'b10));

    step(0, 1, 32'h40335293, 0, 1);
    @(posedge clk); #1;
    check("srai_op", 64'(alu_op), 64'(4'b1110));
    check("srai_imm", 64'(imm), 64'(32'h00000403));
    check("srai_rd", 64'(rd), 64'(5));
    check("srai_src", 64'(alu_src_imm), 64'(1));

    step(0, 1, 32'hFE209CE3, 0, 1);
    @(posedge clk); #1;
    check("bne_op", 64'(alu_op), 64'(4'b1001));
    check("bne_imm", 64'(imm), 64'(32'hFFFFFFF8));
    check("bne_flags", 64'({is_branch, reg_write}), 64'(2'b10));

    step(0, 1, 32'hFFFFFFFF, 0, 1);
    @(posedge clk); #1;
    check("ill_op", 64'(alu_op), 64'(0));
    check("ill_wr", 64'(reg_write), 64'(0));
    check("ill_flag", 64'(illegal), 64'(ILL_EN));

    step(0, 0, 0, 0, 1);
    step(0, 1, I_A, 0, 0);
    step(0, 1, I_B, 0, 0);
    @(posedge clk); #1;
    check("bp_in_ready_drop", 64'(in_ready), 64'(0));
    check("bp_head_1", 64'(rd), 64'(10));
    step(0, 1, I_C, 0, 1);
    @(posedge clk); #1;
    check("bp_head_2", 64'(rd), 64'(11));
    step(0, 1, I_C, 0, 1);
    @(posedge clk); #1;
    check("bp_head_3", 64'(rd), 64'(12));
    step(0, 0, 0, 0, 1);

    step(0, 1, I_A, 0, 0);
    step(0, 1, I_B, 0, 0);
    step(0, 1, I_D, 1, 0);
    @(posedge clk); #1;
    check("flush2_out_valid", 64'(out_valid), 64'(0));
    check("flush2_in_ready", 64'(in_ready), 64'(1));
    step(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("flush2_no_emit", 64'(out_valid), 64'(0));

    step(0, 1, I_A, 0, 0);
    step(0, 1, I_D, 1, 0);
    @(posedge clk); #1;
    check("flush1_drop", 64'(out_valid), 64'(0));

    step(0, 1, I_A, 0, 0);
    step(0, 1, I_B, 0, 0);
    step(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    step(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 7,
           rand_instr(),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6);
    end
    step(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
